// File: rtl/s_axi_reg_pkg.sv
// s_axi_reg_pkg: response codes and FSM state types shared by the register bank slice
package s_axi_reg_pkg;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_SLVERR = 2'b10
    } resp_t;

    typedef enum logic {
        WR_COLLECT = 1'b0,
        WR_RESP    = 1'b1
    } wr_state_t;

    typedef enum logic {
        RD_IDLE = 1'b0,
        RD_DATA = 1'b1
    } rd_state_t;

endpackage

// File: rtl/s_axi_reg_bank_if.sv
// s_axi_reg_bank_if: AXI4-Lite-style AW/W/B/AR/R bundle with master and slave views
interface s_axi_reg_bank_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int ID_W   = 4
);
    localparam int STRB_W = DATA_W / 8;

    logic [ID_W-1:0]   awid_i;
    logic [ADDR_W-1:0] awaddr_i;
    logic              awvalid_i;
    logic              awready_o;
    logic [DATA_W-1:0] wdata_i;
    logic [STRB_W-1:0] wstrb_i;
    logic              wvalid_i;
    logic              wready_o;
    logic [ID_W-1:0]   bid_o;
    logic [1:0]        bresp_o;
    logic              bvalid_o;
    logic              bready_i;
    logic [ID_W-1:0]   arid_i;
    logic [ADDR_W-1:0] araddr_i;
    logic              arvalid_i;
    logic              arready_o;
    logic [ID_W-1:0]   rid_o;
    logic [DATA_W-1:0] rdata_o;
    logic [1:0]        rresp_o;
    logic              rvalid_o;
    logic              rready_i;

    modport slave (
        input  awid_i, awaddr_i, awvalid_i, wdata_i, wstrb_i, wvalid_i, bready_i,
        input  arid_i, araddr_i, arvalid_i, rready_i,
        output awready_o, wready_o, bid_o, bresp_o, bvalid_o,
        output arready_o, rid_o, rdata_o, rresp_o, rvalid_o
    );

    modport master (
        output awid_i, awaddr_i, awvalid_i, wdata_i, wstrb_i, wvalid_i, bready_i,
        output arid_i, araddr_i, arvalid_i, rready_i,
        input  awready_o, wready_o, bid_o, bresp_o, bvalid_o,
        input  arready_o, rid_o, rdata_o, rresp_o, rvalid_o
    );

endinterface

// File: rtl/s_axi_strb_merge.sv
// s_axi_strb_merge: per-byte select of new data over the old word where the strobe is set
module s_axi_strb_merge #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0]   old_word,
    input  logic [DATA_W-1:0]   new_word,
    input  logic [DATA_W/8-1:0] strb,
    output logic [DATA_W-1:0]   merged
);
    for (genvar b = 0; b < DATA_W / 8; b++) begin : g_byte
        assign merged[8*b +: 8] = strb[b] ? new_word[8*b +: 8] : old_word[8*b +: 8];
    end
endmodule

// File: rtl/s_axi_reg_bank.sv
// s_axi_reg_bank: word-indexed AXI4-Lite-style register file with independent AW/W capture,
// byte strobes and SLVERR on out-of-range indices. Define S_AXI_REG_BANK_WCNT_EN to add a
// read-only write-commit counter at index NUM_REGS.
module s_axi_reg_bank
    import s_axi_reg_pkg::*;
#(
    parameter int              DATA_W    = 32,
    parameter int              ADDR_W    = 32,
    parameter int              ID_W      = 4,
    parameter int              NUM_REGS  = 4,
    parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
    input logic              clk,
    input logic              areset,
    s_axi_reg_bank_if.slave  bus
);
    localparam int STRB_W = DATA_W / 8;
    localparam int IDX_W  = NUM_REGS > 1 ? $clog2(NUM_REGS) : 1;
    localparam logic [ADDR_W-1:0] LIMIT = ADDR_W'(NUM_REGS);

    logic [DATA_W-1:0] regs [NUM_REGS];

    wr_state_t         wr_state;
    logic              aw_held, w_held, awready, wready, bvalid;
    logic [ID_W-1:0]   awid_q, bid;
    logic [ADDR_W-1:0] aw_idx;
    logic [DATA_W-1:0] wdata_q, merged;
    logic [STRB_W-1:0] wstrb_q;
    resp_t             bresp;

    rd_state_t         rd_state;
    logic              arready, rvalid;
    logic [ID_W-1:0]   rid;
    logic [DATA_W-1:0] rdata, cnt_val;
    resp_t             rresp;

    logic commit, wr_hit, rd_hit, rd_cnt;

    // Full-width compares so large indices never alias onto a real register
    assign commit = wr_state == WR_COLLECT && aw_held && w_held;
    assign wr_hit = aw_idx < LIMIT;
    assign rd_hit = bus.araddr_i < LIMIT;

    s_axi_strb_merge #(.DATA_W(DATA_W)) u_merge (
        .old_word (regs[aw_idx[IDX_W-1:0]]),
        .new_word (wdata_q),
        .strb     (wstrb_q),
        .merged   (merged)
    );

`ifdef S_AXI_REG_BANK_WCNT_EN
    logic [DATA_W-1:0] wcnt;

    // Count successful register commits; wraps naturally at 2^DATA_W
    always_ff @(posedge clk or negedge areset) begin
        if (!areset) wcnt <= '0;
        else if (commit && wr_hit) wcnt <= wcnt + DATA_W'(1);
    end

    assign rd_cnt  = bus.araddr_i == LIMIT;
    assign cnt_val = wcnt;
`else
    assign rd_cnt  = 1'b0;
    assign cnt_val = '0;
`endif

    // Register array: strobe-merged update of the addressed word on an in-range commit
    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= RESET_VAL;
        end else begin
            for (int i = 0; i < NUM_REGS; i++)
                if (commit && wr_hit && aw_idx == ADDR_W'(i)) regs[i] <= merged;
        end
    end

    // Write FSM: collect AW and W in any order, commit once both are held, hold B until accepted
    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            wr_state <= WR_COLLECT;
            aw_held  <= 1'b0;
            w_held   <= 1'b0;
            awready  <= 1'b0;
            wready   <= 1'b0;
            bvalid   <= 1'b0;
            bid      <= '0;
            bresp    <= RESP_OKAY;
            awid_q   <= '0;
            aw_idx   <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
        end else if (wr_state == WR_RESP) begin
            if (bus.bready_i) begin
                wr_state <= WR_COLLECT;
                bvalid   <= 1'b0;
                aw_held  <= 1'b0;
                w_held   <= 1'b0;
                awready  <= 1'b1;
                wready   <= 1'b1;
            end
        end else if (commit) begin
            wr_state <= WR_RESP;
            bvalid   <= 1'b1;
            bid      <= awid_q;
            bresp    <= wr_hit ? RESP_OKAY : RESP_SLVERR;
        end else begin
            if (bus.awvalid_i && awready) begin
                aw_held <= 1'b1;
                awready <= 1'b0;
                awid_q  <= bus.awid_i;
                aw_idx  <= bus.awaddr_i;
            end else begin
                awready <= ~aw_held;
            end
            if (bus.wvalid_i && wready) begin
                w_held  <= 1'b1;
                wready  <= 1'b0;
                wdata_q <= bus.wdata_i;
                wstrb_q <= bus.wstrb_i;
            end else begin
                wready <= ~w_held;
            end
        end
    end

    // Read FSM: sample the addressed word on AR, present it next cycle, hold until accepted
    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            rd_state <= RD_IDLE;
            arready  <= 1'b0;
            rvalid   <= 1'b0;
            rid      <= '0;
            rdata    <= '0;
            rresp    <= RESP_OKAY;
        end else if (rd_state == RD_DATA) begin
            if (bus.rready_i) begin
                rd_state <= RD_IDLE;
                rvalid   <= 1'b0;
                arready  <= 1'b1;
            end
        end else if (bus.arvalid_i && arready) begin
            rd_state <= RD_DATA;
            arready  <= 1'b0;
            rvalid   <= 1'b1;
            rid      <= bus.arid_i;
            rdata    <= rd_hit ? regs[bus.araddr_i[IDX_W-1:0]] : rd_cnt ? cnt_val : '0;
            rresp    <= rd_hit || rd_cnt ? RESP_OKAY : RESP_SLVERR;
        end else begin
            arready <= 1'b1;
        end
    end

    assign bus.awready_o = awready;
    assign bus.wready_o  = wready;
    assign bus.bvalid_o  = bvalid;
    assign bus.bid_o     = bid;
    assign bus.bresp_o   = bresp;
    assign bus.arready_o = arready;
    assign bus.rvalid_o  = rvalid;
    assign bus.rid_o     = rid;
    assign bus.rdata_o   = rdata;
    assign bus.rresp_o   = rresp;

endmodule

// File: tb/tb_s_axi_reg_bank.sv
// tb_s_axi_reg_bank: directed stimulus with a transaction-level model checked every cycle
module tb_s_axi_reg_bank;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int IW = 4;
    localparam int NR = 4;
`ifdef S_AXI_REG_BANK_WCNT_EN
    localparam bit WCNT = 1'b1;
`else
    localparam bit WCNT = 1'b0;
`endif

    logic clk = 1'b0;
    logic areset = 1'b0;
    always #5 clk = ~clk;

    s_axi_reg_bank_if #(.DATA_W(DW), .ADDR_W(AW), .ID_W(IW)) bus ();

    s_axi_reg_bank #(
        .DATA_W(DW), .ADDR_W(AW), .ID_W(IW), .NUM_REGS(NR), .RESET_VAL('0)
    ) dut (
        .clk    (clk),
        .areset (areset),
        .bus    (bus)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Transaction-level model: what the bank must hold and answer
    logic [DW-1:0] mregs [NR];
    logic [DW-1:0] mcnt;
    bit            m_aw, m_w, m_b, m_r;
    logic [AW-1:0] m_idx;
    logic [IW-1:0] m_awid, m_bid, m_rid;
    logic [DW-1:0] m_wd, m_rd;
    logic [3:0]    m_ws;
    logic [1:0]    m_bresp, m_rresp;

    function automatic logic [DW-1:0] apply_strb(input logic [DW-1:0] old, input logic [DW-1:0] nw,
                                                 input logic [3:0] s);
        logic [DW-1:0] mask;
        mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
        return (old & ~mask) | (nw & mask);
    endfunction

    always @(posedge clk) begin
        if (!areset) begin
            m_aw = 0; m_w = 0; m_b = 0; m_r = 0; mcnt = '0;
            for (int i = 0; i < NR; i++) mregs[i] = '0;
        end else begin
            if (bus.rvalid_o && bus.rready_i) m_r = 0;
            if (bus.arvalid_i && bus.arready_o) begin
                m_r = 1;
                m_rid = bus.arid_i;
                if (bus.araddr_i < NR) begin
                    m_rd = mregs[bus.araddr_i[1:0]]; m_rresp = 2'b00;
                end else if (WCNT && bus.araddr_i == NR) begin
                    m_rd = mcnt; m_rresp = 2'b00;
                end else begin
                    m_rd = '0; m_rresp = 2'b10;
                end
            end
            if (bus.bvalid_o && bus.bready_i) begin
                m_b = 0; m_aw = 0; m_w = 0;
            end else if (m_aw && m_w && !m_b) begin
                m_b = 1;
                m_bid = m_awid;
                if (m_idx < NR) begin
                    mregs[m_idx[1:0]] = apply_strb(mregs[m_idx[1:0]], m_wd, m_ws);
                    mcnt = mcnt + 1;
                    m_bresp = 2'b00;
                end else begin
                    m_bresp = 2'b10;
                end
            end else begin
                if (bus.awvalid_i && bus.awready_o) begin
                    m_aw = 1; m_awid = bus.awid_i; m_idx = bus.awaddr_i;
                end
                if (bus.wvalid_i && bus.wready_o) begin
                    m_w = 1; m_wd = bus.wdata_i; m_ws = bus.wstrb_i;
                end
            end
        end
    end

    // Compare process: outputs against the model every cycle, all-zero during reset
    always @(negedge clk) begin
        if (!areset) begin
            chk("reset_outputs", {bus.awready_o, bus.wready_o, bus.arready_o, bus.bvalid_o, bus.rvalid_o,
                                  bus.bid_o, bus.rid_o, bus.bresp_o, bus.rresp_o, bus.rdata_o}, '0);
        end else begin
            chk("bvalid", bus.bvalid_o, m_b);
            if (m_b) chk("bid_bresp", {bus.bid_o, bus.bresp_o}, {m_bid, m_bresp});
            chk("rvalid", bus.rvalid_o, m_r);
            if (m_r) chk("rid_rresp_rdata", {bus.rid_o, bus.rresp_o, bus.rdata_o}, {m_rid, m_rresp, m_rd});
            if (m_aw || m_b) chk("awready_busy", bus.awready_o, 1'b0);
            if (m_w || m_b) chk("wready_busy", bus.wready_o, 1'b0);
            if (m_r) chk("arready_busy", bus.arready_o, 1'b0);
        end
    end

    task automatic do_write(input logic [AW-1:0] idx, input logic [IW-1:0] id, input logic [DW-1:0] d,
                            input logic [3:0] s, input bit with_w, input int bdly, output logic [1:0] resp);
        bit a_ok, w_ok;
        int n;
        @(negedge clk);
        bus.awaddr_i = idx; bus.awid_i = id; bus.awvalid_i = 1'b1;
        if (with_w) begin
            bus.wdata_i = d; bus.wstrb_i = s; bus.wvalid_i = 1'b1;
        end
        n = 0;
        while ((bus.awvalid_i || bus.wvalid_i) && n < 20) begin
            a_ok = bus.awvalid_i && bus.awready_o;
            w_ok = bus.wvalid_i && bus.wready_o;
            @(negedge clk);
            if (a_ok) bus.awvalid_i = 1'b0;
            if (w_ok) bus.wvalid_i = 1'b0;
            n++;
        end
        bus.awvalid_i = 1'b0; bus.wvalid_i = 1'b0;
        n = 0;
        while (!bus.bvalid_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!bus.bvalid_o) begin
            chk("b_timeout", bus.bvalid_o, 1'b1);
            resp = 2'b11;
            return;
        end
        for (int k = 0; k < bdly; k++) begin
            chk("b_hold", {bus.bvalid_o, bus.bid_o, bus.awready_o, bus.wready_o}, {1'b1, id, 2'b00});
            @(negedge clk);
        end
        resp = bus.bresp_o;
        bus.bready_i = 1'b1;
        @(negedge clk);
        bus.bready_i = 1'b0;
    endtask

    task automatic do_read(input logic [AW-1:0] idx, input logic [IW-1:0] id, input int rdly,
                           output logic [DW-1:0] d, output logic [1:0] resp);
        bit a_ok;
        int n;
        @(negedge clk);
        bus.araddr_i = idx; bus.arid_i = id; bus.arvalid_i = 1'b1;
        n = 0;
        while (bus.arvalid_i && n < 20) begin
            a_ok = bus.arready_o;
            @(negedge clk);
            if (a_ok) bus.arvalid_i = 1'b0;
            n++;
        end
        bus.arvalid_i = 1'b0;
        n = 0;
        while (!bus.rvalid_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!bus.rvalid_o) begin
            chk("r_timeout", bus.rvalid_o, 1'b1);
            d = '0; resp = 2'b11;
            return;
        end
        for (int k = 0; k < rdly; k++) begin
            chk("r_hold", {bus.rvalid_o, bus.rid_o, bus.arready_o}, {1'b1, id, 1'b0});
            @(negedge clk);
        end
        d = bus.rdata_o;
        resp = bus.rresp_o;
        bus.rready_i = 1'b1;
        @(negedge clk);
        bus.rready_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [DW-1:0] rd;
        logic [1:0]    rr, br;
        bus.awid_i = '0; bus.awaddr_i = '0; bus.awvalid_i = 1'b0;
        bus.wdata_i = '0; bus.wstrb_i = '0; bus.wvalid_i = 1'b0; bus.bready_i = 1'b0;
        bus.arid_i = '0; bus.araddr_i = '0; bus.arvalid_i = 1'b0; bus.rready_i = 1'b0;
        repeat (3) @(negedge clk);
        #2 areset = 1'b1;
        @(negedge clk);
        chk("readies_after_release", {bus.awready_o, bus.wready_o, bus.arready_o}, 3'b111);

        // W before AW, W held three cycles
        bus.wdata_i = 32'hC2CCEE2E; bus.wstrb_i = 4'hF; bus.wvalid_i = 1'b1;
        @(negedge clk);
        chk("t1_wready_dropped", bus.wready_o, 1'b0);
        chk("t1_awready_still_up", bus.awready_o, 1'b1);
        repeat (2) @(negedge clk);
        bus.wvalid_i = 1'b0;
        do_write(1, 4'h1, '0, 4'h0, 1'b0, 0, br);
        chk("t1_bresp", br, 2'b00);
        do_read(1, 4'h1, 0, rd, rr);
        chk("t1_read", {rr, rd}, {2'b00, 32'hC2CCEE2E});

        // Byte strobes
        do_write(2, 4'h2, 32'h0, 4'hF, 1'b1, 0, br);
        do_write(2, 4'h2, 32'hA3DDDD3F, 4'b1010, 1'b1, 0, br);
        chk("t2_bresp", br, 2'b00);
        do_read(2, 4'h2, 0, rd, rr);
        chk("t2_read", rd, 32'hA300DD00);

        // Out of range
        do_write(7, 4'h3, 32'hFFFFFFFF, 4'hF, 1'b1, 0, br);
        chk("t3_bresp_slverr", br, 2'b10);
        do_read(0, 4'h0, 0, rd, rr); chk("t3_reg0", rd, 32'h0);
        do_read(1, 4'h0, 0, rd, rr); chk("t3_reg1", rd, 32'hC2CCEE2E);
        do_read(2, 4'h0, 0, rd, rr); chk("t3_reg2", rd, 32'hA300DD00);
        do_read(3, 4'h0, 0, rd, rr); chk("t3_reg3", rd, 32'h0);
`ifndef S_AXI_REG_BANK_WCNT_EN
        do_read(4, 4'h4, 0, rd, rr);
        chk("t3_read4", {rr, rd}, {2'b10, 32'h0});
`endif
        do_read(NR + 4, 4'h4, 0, rd, rr);
        chk("t3_read_nowrap", {rr, rd}, {2'b10, 32'h0});
        do_read(32'h8000_0001, 4'h4, 0, rd, rr);
        chk("t3_read_fullwidth", {rr, rd}, {2'b10, 32'h0});

        // Backpressure on B and R
        do_write(3, 4'h5, 32'h12345678, 4'hF, 1'b1, 5, br);
        chk("t4_bresp", br, 2'b00);
        do_read(3, 4'hA, 5, rd, rr);
        chk("t4_read", {rr, rd}, {2'b00, 32'h12345678});

        // Concurrent read and write of the same register
        do_write(0, 4'h6, 32'h7778111A, 4'hF, 1'b1, 0, br);
        fork
            do_read(0, 4'h7, 0, rd, rr);
            do_write(0, 4'h8, 32'h0000FFFF, 4'hF, 1'b1, 0, br);
        join
        chk("t5_read_old", rd, 32'h7778111A);
        do_read(0, 4'h9, 0, rd, rr);
        chk("t5_read_new", rd, 32'h0000FFFF);

        // Reset in the middle of a write
        @(negedge clk);
        bus.awaddr_i = 3; bus.awid_i = 4'h2; bus.awvalid_i = 1'b1;
        @(negedge clk);
        bus.awvalid_i = 1'b0;
        chk("t6_aw_captured", bus.awready_o, 1'b0);
        #2 areset = 1'b0;
        repeat (3) @(negedge clk);
        #2 areset = 1'b1;
        repeat (3) @(negedge clk);
        chk("t6_no_b", bus.bvalid_o, 1'b0);
        do_read(3, 4'h1, 0, rd, rr);
        chk("t6_reg3_reset", {rr, rd}, {2'b00, 32'h0});

`ifdef S_AXI_REG_BANK_WCNT_EN
        do_write(0, 4'h1, 32'h1, 4'hF, 1'b1, 0, br);
        do_write(1, 4'h1, 32'h2, 4'h1, 1'b1, 0, br);
        do_write(2, 4'h1, 32'h3, 4'h0, 1'b1, 0, br);
        do_read(NR, 4'hC, 0, rd, rr);
        chk("wcnt_three", {rr, rd}, {2'b00, 32'd3});
        do_write(NR, 4'hD, 32'hFFFF, 4'hF, 1'b1, 0, br);
        chk("wcnt_write_slverr", br, 2'b10);
        do_read(NR, 4'hC, 0, rd, rr);
        chk("wcnt_unchanged", {rr, rd}, {2'b00, 32'd3});
`endif

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
